// File: rtl/multi_edge_detector_pkg.sv
// multi_edge_detector_pkg
//   Shared definitions for the multi-channel edge detector.
//   MAX_CHANNELS     : upper bound on the CHANNELS parameter.
//   DEFAULT_FILTER_W : default width of the glitch-filter counter.
//   edge_kind_t      : per-channel accepted-edge classification.
package multi_edge_detector_pkg;

  localparam int unsigned MAX_CHANNELS     = 32;
  localparam int unsigned DEFAULT_FILTER_W = 4;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_kind_t;

endpackage

// File: rtl/multi_edge_detector_if.sv
// multi_edge_detector_if
//   Groups the detector's data/control inputs and event outputs.
//   din, rise_en, fall_en, clr, irq_mask, filt_thresh : driven by master
//   level, pulse, status, irq                         : driven by slave (detector)
//   modport master : the controlling side (e.g. bench or system glue)
//   modport slave  : the multi_edge_detector itself
interface multi_edge_detector_if
  import multi_edge_detector_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned FILTER_W = DEFAULT_FILTER_W
);

  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] rise_en;
  logic [CHANNELS-1:0] fall_en;
  logic [FILTER_W-1:0] filt_thresh;
  logic [CHANNELS-1:0] clr;
  logic [CHANNELS-1:0] irq_mask;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] status;
  logic                irq;

  modport master (
    output din, rise_en, fall_en, filt_thresh, clr, irq_mask,
    input  level, pulse, status, irq
  );

  modport slave (
    input  din, rise_en, fall_en, filt_thresh, clr, irq_mask,
    output level, pulse, status, irq
  );

endinterface

// File: rtl/multi_edge_detector_chan.sv
// edge_filter_chan
//   One channel: glitch filter counter, accepted level and edge classification.
//   Build option: MULTI_EDGE_DETECTOR_FILTER_EN builds the counter; without it
//   the accepted level follows din every cycle and filt_thresh is ignored.
//   clk, resetn (sync, active-low)
//   din         : input level, synchronous to clk
//   filt_thresh : stable cycles required beyond the first differing sample
//   level       : accepted (filtered) level
//   kind        : edge accepted on the coming clock edge (combinational)
module edge_filter_chan
  import multi_edge_detector_pkg::*;
#(
  parameter int unsigned FILTER_W = DEFAULT_FILTER_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                din,
  input  logic [FILTER_W-1:0] filt_thresh,
  output logic                level,
  output edge_kind_t          kind
);

  logic level_q;
  logic accept;

`ifdef MULTI_EDGE_DETECTOR_FILTER_EN
  logic [FILTER_W-1:0] cnt_q;

  // cnt_q holds the number of earlier consecutive differing samples, so the
  // current differing sample is accepted once that count meets the threshold.
  always_comb begin
    accept = (din != level_q) && (cnt_q >= filt_thresh);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else if (din == level_q) begin
      cnt_q   <= '0;
    end else if (accept) begin
      level_q <= din;
      cnt_q   <= '0;
    end else begin
      cnt_q   <= cnt_q + FILTER_W'(1);
    end
  end
`else
  logic unused_thresh;

  always_comb begin
    unused_thresh = ^filt_thresh;
    accept        = (din != level_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      level_q <= 1'b0;
    end else begin
      level_q <= din;
    end
  end
`endif

  always_comb begin
    kind = EDGE_NONE;
    if (accept) begin
      kind = din ? EDGE_RISE : EDGE_FALL;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//   Multi-channel edge detector with optional glitch filter, per-channel
//   rise/fall selection, registered one-cycle pulses, sticky status with
//   clear, and a masked, registered aggregate interrupt.
//   Build option: MULTI_EDGE_DETECTOR_FILTER_EN enables the glitch filter.
//   clk    : clock
//   resetn : synchronous, active-low reset
//   bus    : multi_edge_detector_if.slave (din, rise_en, fall_en, filt_thresh,
//            clr, irq_mask in; level, pulse, status, irq out)
module multi_edge_detector
  import multi_edge_detector_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned FILTER_W = DEFAULT_FILTER_W
) (
  input  logic clk,
  input  logic resetn,
  multi_edge_detector_if.slave bus
);

  edge_kind_t          kind [CHANNELS];
  logic [CHANNELS-1:0] level_vec;
  logic [CHANNELS-1:0] pulse_next;
  logic [CHANNELS-1:0] status_next;
  logic [CHANNELS-1:0] pulse_q;
  logic [CHANNELS-1:0] status_q;
  logic                irq_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_filter_chan #(
      .FILTER_W (FILTER_W)
    ) u_chan (
      .clk         (clk),
      .resetn      (resetn),
      .din         (bus.din[i]),
      .filt_thresh (bus.filt_thresh),
      .level       (level_vec[i]),
      .kind        (kind[i])
    );
  end

  always_comb begin
    pulse_next = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pulse_next[i] = ((kind[i] == EDGE_RISE) && bus.rise_en[i]) ||
                      ((kind[i] == EDGE_FALL) && bus.fall_en[i]);
    end
  end

  // Set wins over clear when both occur in the same cycle.
  always_comb begin
    status_next = (status_q & ~bus.clr) | pulse_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pulse_q  <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      pulse_q  <= pulse_next;
      status_q <= status_next;
      irq_q    <= |(status_next & bus.irq_mask);
    end
  end

  assign bus.level  = level_vec;
  assign bus.pulse  = pulse_q;
  assign bus.status = status_q;
  assign bus.irq    = irq_q;

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Multi-channel, parametrised edge detector: the next generation of the single-input rising-edge pulser. Each channel has an optional glitch filter, per-channel rising/falling edge selection, a one-cycle registered pulse, a sticky status bit with clear, and a masked, aggregated interrupt. The block sits between synchronised GPIO/status inputs and the interrupt/event logic.

## Interface
- CHANNELS, 8: number of independent input channels (1..32).
- FILTER_W, 4: width of the per-channel filter counter and of `filt_thresh`.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- din  in  CHANNELS  input levels, already synchronous to `clk`.
- rise_en  in  CHANNELS  per-channel enable for rising-edge events.
- fall_en  in  CHANNELS  per-channel enable for falling-edge events.
- filt_thresh  in  FILTER_W  stable cycles required beyond the first differing sample; shared by all channels.
- clr  in  CHANNELS  clear for the `status` bits; one-cycle strobe, 1 clears.
- irq_mask  in  CHANNELS  1 lets a channel's `status` contribute to `irq`.
- level  out  CHANNELS  filtered level per channel (`level_q`).
- pulse  out  CHANNELS  one-cycle event pulse per channel, registered.
- status  out  CHANNELS  sticky event flags.
- irq  out  1  registered OR of `status & irq_mask`.

## Operation
- Per channel, `level_q` holds the accepted level. `cnt_q` (FILTER_W bits) counts consecutive cycles in which `din != level_q`.
  - If `din == level_q`: `cnt_q <= 0`.
  - If `din != level_q` and `cnt_q < filt_thresh`: `cnt_q <= cnt_q + 1`.
  - If `din != level_q` and `cnt_q >= filt_thresh`: `level_q <= din`, `cnt_q <= 0`, and an edge is accepted.
  - `cnt_q` never exceeds `filt_thresh`, so it cannot wrap.
- Accepted 0->1 is a rise; accepted 1->0 is a fall.
- `pulse_q[i] <= (rise & rise_en[i]) | (fall & fall_en[i])`, registered on the same edge that updates `level_q`.
- `status_q[i]` is set by `pulse_next[i]` and cleared by `clr[i]`. A simultaneous set and clear leaves status = 1 (set wins).
- `irq_q <= |(status_next & irq_mask)`.
- Changes to `rise_en`, `fall_en` or `irq_mask` take effect from the next clock. They never generate a pulse by themselves.
- Channels are fully independent; simultaneous edges on several channels all pulse in the same cycle.

## Timing
- Reset: `level_q`, `cnt_q`, `pulse_q`, `status_q` and `irq_q` all go to 0.
- `din` high at reset release is seen as a rise after the filter delay.
- Latency: `din` changed and held, first sampled at edge k. `level` and `pulse` assert after edge k + `filt_thresh`.
- With `filt_thresh` = 0 this is 1 cycle after sampling, identical to the legacy pulser.
- `pulse` lasts exactly one cycle per accepted edge. A constant input never re-pulses.
- A glitch shorter than `filt_thresh + 1` samples is suppressed: no level change, no pulse, counter returns to 0.
- `irq` trails `status` by 0 cycles; both update on the same edge.
- Changing `filt_thresh` mid-count applies to the next comparison. If `cnt_q` already meets or exceeds the new value, the edge is accepted at the next differing sample.
- `resetn` low mid-count discards the pending edge; no pulse is produced.

## Configuration
- `MULTI_EDGE_DETECTOR_FILTER_EN`
  - Defined: the glitch filter is built as described.
  - Undefined: no counters are built and `filt_thresh` is ignored. `level_q <= din` every cycle, so every edge is accepted with 1-cycle latency.
  - All other behaviour is identical in both builds.

## Structure
- Package `multi_edge_detector_pkg` holds:
  - `MAX_CHANNELS` = 32.
  - Default `FILTER_W`.
  - Typedef `edge_kind_t` {EDGE_NONE, EDGE_RISE, EDGE_FALL}, used by the channel sub-module's event output.
- Sub-module `edge_filter_chan`: one channel's filter counter, `level_q` and edge classification. It is instantiated CHANNELS times in a generate loop.
- Top level holds the pulse, status and irq registers.

## Test plan
- `filt_thresh` = 0, `rise_en` = all 1, ch0 `din` 0->1 held -> `pulse[0]` high exactly one cycle, 1 cycle after sampling; `status[0]` = 1.
- `filt_thresh` = 3, ch2 high for 3 cycles then low -> no pulse, `level[2]` stays 0. Held for 4 cycles -> pulse 4 cycles after first sample.
- `fall_en[1]` = 1, `rise_en[1]` = 0, ch1 toggles 0->1->0 -> exactly one pulse, on the fall.
- `status[3]` set, `irq_mask[3]` = 1 -> `irq` = 1. `clr[3]` in the same cycle as a new ch3 edge -> `status[3]` stays 1. Later `clr[3]` alone -> `status[3]` and `irq` both 0.
- All 8 channels rise in the same cycle with `irq_mask` = 0 -> 8 simultaneous pulses, `status` = 0xFF, `irq` = 0.
- `resetn` low while ch5 is mid-filter -> all outputs 0 and no pulse. `din` still high after release -> rise after `filt_thresh` + 1 cycles.
